// File: rtl/spi_temp_pkg.sv
// Shared types and default parameters for the SPI temperature reader and its neighbours.
package spi_temp_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int DEF_CLK_DIV    = 25;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_TEMP_BITS  = 13;

endpackage

// File: rtl/spi_temp_reader_if.sv
// Sensor-side SPI pins: the reader is master, the sensor (or its model) is slave.
interface spi_temp_reader_if;

    logic spi_sclk_out;
    logic spi_cs_n_out;
    logic spi_miso_in;

    modport master (output spi_sclk_out, output spi_cs_n_out, input spi_miso_in);
    modport slave  (input spi_sclk_out, input spi_cs_n_out, output spi_miso_in);

endinterface

// File: rtl/spi_sclk_div.sv
// SCLK half-period counter: counts 0..CLK_DIV-1 while enabled, tick_o on the last count.
module spi_sclk_div #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clear_i && at_end;

endmodule

// File: rtl/spi_temp_reader.sv
// Trigger-driven SPI read of a temperature sensor (mode 0, MSB first, read-only).
// IDLE cs high | SETUP cs low, sclk low | SHIFT clock bits | HOLD cs low, sclk low | DONE publish result
module spi_temp_reader
    import spi_temp_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int TEMP_BITS  = DEF_TEMP_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  trig_in,
    spi_temp_reader_if.master     spi_if,
    output logic [TEMP_BITS-1:0]  temp_out,
    output logic                  temp_valid_out,
    output logic                  busy_out,
    output logic                  overrun_out
);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_temp_reader: CLK_DIV must be at least 1");
    end
    if (TEMP_BITS > FRAME_BITS) begin : g_bad_temp_bits
        $error("spi_temp_reader: TEMP_BITS must not exceed FRAME_BITS");
    end

    localparam int BW = $clog2(FRAME_BITS + 1);

    state_t                 state_q;
    logic                   trig_prev_q;
    logic                   sclk_q;
    logic                   cs_n_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic [FRAME_BITS-1:0]  sreg_q;
    logic [BW-1:0]          bit_q;
    logic [TEMP_BITS-1:0]   temp_q;
    logic                   start;
    logic                   div_en;
    logic                   tick;

    assign start  = trig_in & ~trig_prev_q;
    assign div_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .en_i    (div_en),
        .clear_i (~div_en),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            trig_prev_q <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            sreg_q      <= '0;
            bit_q       <= '0;
            temp_q      <= '0;
        end else begin
            trig_prev_q <= trig_in;
            valid_q     <= 1'b0;
            // A start that lands on any non-idle cycle, DONE included, is dropped and flagged.
            overrun_q   <= start && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            sreg_q <= {sreg_q[FRAME_BITS-2:0], spi_if.spi_miso_in};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == BW'(FRAME_BITS - 1)) begin
                                bit_q   <= '0;
                                state_q <= HOLD;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q <= DONE;
                        cs_n_q  <= 1'b1;
                    end
                end
                DONE: begin
                    temp_q  <= sreg_q[FRAME_BITS-1 -: TEMP_BITS];
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spi_if.spi_sclk_out = sclk_q;
    assign spi_if.spi_cs_n_out = cs_n_q;
    assign temp_out            = temp_q;
    assign temp_valid_out      = valid_q;
    assign busy_out            = (state_q != IDLE);
    assign overrun_out         = overrun_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Bench for spi_temp_reader: constant vectors, hand-written corner sequences and random trigger
// patterns checked cycle by cycle against an interval-based reference model.
module tb_spi_temp_reader;

    localparam int CD     = 2;
    localparam int FB     = 16;
    localparam int TB     = 13;
    localparam int CS_LOW = CD * (2 * FB + 2);
    localparam int LAT    = CS_LOW + 2;
    localparam int MAXC   = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic [TB-1:0] temp;
    logic          valid, busy, ovr;

    spi_temp_reader_if bus ();

    spi_temp_reader #(.CLK_DIV(CD), .FRAME_BITS(FB), .TEMP_BITS(TB)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .trig_in        (trig),
        .spi_if         (bus.master),
        .temp_out       (temp),
        .temp_valid_out (valid),
        .busy_out       (busy),
        .overrun_out    (ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Behavioural sensor: MSB on cs_n fall, next bit on each SCLK fall.
    logic [FB-1:0] sensor_q[$];
    logic [FB-1:0] cur_frame = '0;
    int            bit_idx = 0;
    logic          cs_p = 1'b1, sc_p = 1'b0;

    initial begin
        bus.spi_miso_in = 1'b0;
        forever begin
            @(bus.spi_cs_n_out or bus.spi_sclk_out);
            if (cs_p === 1'b1 && bus.spi_cs_n_out === 1'b0) begin
                cur_frame = (sensor_q.size() > 0) ? sensor_q.pop_front() : '0;
                bit_idx = FB - 1;
                bus.spi_miso_in = cur_frame[FB-1];
            end else if (sc_p === 1'b1 && bus.spi_sclk_out === 1'b0 && bit_idx > 0) begin
                bit_idx--;
                bus.spi_miso_in = cur_frame[bit_idx];
            end
            cs_p = bus.spi_cs_n_out;
            sc_p = bus.spi_sclk_out;
        end
    end

    int n_rises = 0, n_cs_low = 0, n_sclk_bad = 0;

    always @(posedge bus.spi_sclk_out) n_rises++;

    always @(negedge clk) begin
        if (bus.spi_cs_n_out === 1'b0) n_cs_low++;
        if (bus.spi_cs_n_out === 1'b1 && bus.spi_sclk_out === 1'b1) n_sclk_bad++;
    end

    // Reference model: each accepted start at cycle s owns cs-low [s+1, s+CS_LOW],
    // busy [s+1, s+CS_LOW+1] and a result at s+LAT; rises inside a busy window are overruns.
    bit            ev[MAXC], eo[MAXC], eb[MAXC], ecs[MAXC];
    logic [TB-1:0] etv[MAXC];
    bit            vq[$];
    logic [FB-1:0] fq[$];
    logic [TB-1:0] cur_temp = '0;
    int            seq_valids, seq_first, seq_ovr, model_valids;

    task automatic run_seq(input string nm);
        int            n;
        int            fidx;
        bit            prev;
        logic [FB-1:0] fr;
        logic [31:0]   act, exp;
        n = vq.size() + LAT + 10;
        fidx = 0;
        prev = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            ev[i] = 0; eo[i] = 0; eb[i] = 0; ecs[i] = 1; etv[i] = '0;
        end
        sensor_q.delete();
        foreach (fq[k]) sensor_q.push_back(fq[k]);
        seq_valids = 0; seq_first = -1; seq_ovr = 0; model_valids = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ev[i]) cur_temp = etv[i];
            act = {15'b0, bus.spi_cs_n_out, busy, valid, ovr, temp};
            exp = {15'b0, ecs[i], eb[i], ev[i], eo[i], cur_temp};
            check($sformatf("%s cyc %0d {cs_n,busy,valid,ovr,temp}", nm, i), act, exp);
            if (valid === 1'b1) begin
                seq_valids++;
                if (seq_first < 0) seq_first = i;
            end
            if (ovr === 1'b1) seq_ovr++;
            trig = (i < vq.size()) ? vq[i] : 1'b0;
            if (trig && !prev) begin
                if (eb[i]) begin
                    eo[i+1] = 1;
                end else begin
                    for (int k = 1; k <= CS_LOW + 1; k++) eb[i+k] = 1;
                    for (int k = 1; k <= CS_LOW; k++) ecs[i+k] = 0;
                    fr = (fidx < fq.size()) ? fq[fidx] : '0;
                    fidx++;
                    ev[i+LAT]  = 1;
                    etv[i+LAT] = fr[FB-1 -: TB];
                    model_valids++;
                end
            end
            prev = trig;
        end
    endtask

    typedef struct {
        logic [FB-1:0] frame;
        logic [TB-1:0] temp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int r0, c0, lvl, len;

        tbl[0] = '{16'h0C80, 13'h0190};
        tbl[1] = '{16'hE700, 13'h1CE0};
        tbl[2] = '{16'h0000, 13'h0000};
        tbl[3] = '{16'hFFFF, 13'h1FFF};
        tbl[4] = '{16'h7FF8, 13'h0FFF};
        tbl[5] = '{16'h8000, 13'h1000};
        tbl[6] = '{16'h1234, 13'h0246};
        tbl[7] = '{16'h0C87, 13'h0190};

        // Reset held with trig toggling: everything stays at reset values.
        rst_n = 1'b0;
        trig  = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset cyc %0d {cs_n,sclk,busy,valid,ovr,temp}", i),
                  {14'b0, bus.spi_cs_n_out, bus.spi_sclk_out, busy, valid, ovr, temp},
                  {14'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0});
            trig = ~trig;
        end
        trig = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset no sclk rises", n_rises, 0);
        check("idle after reset {cs_n,busy}", {bus.spi_cs_n_out, busy}, 2'b10);

        // Single-frame vectors: latency, edge count, cs window and decoded field.
        foreach (tbl[t]) begin
            r0 = n_rises;
            c0 = n_cs_low;
            vq.delete(); vq.push_back(1'b1);
            fq.delete(); fq.push_back(tbl[t].frame);
            run_seq($sformatf("vec%0d", t));
            check($sformatf("vec%0d latency", t), seq_first, LAT);
            check($sformatf("vec%0d valid count", t), seq_valids, 1);
            check($sformatf("vec%0d temp", t), temp, tbl[t].temp);
            check($sformatf("vec%0d sclk rises", t), n_rises - r0, FB);
            check($sformatf("vec%0d cs low cycles", t), n_cs_low - c0, CS_LOW);
        end

        // Second rise 20 cycles into a frame: one overrun, frame unaffected.
        vq.delete();
        for (int i = 0; i < 30; i++) vq.push_back(i == 0 || i == 20);
        fq.delete(); fq.push_back(16'h0C80); fq.push_back(16'hE700);
        r0 = n_rises;
        run_seq("overrun");
        check("overrun pulses", seq_ovr, 1);
        check("overrun valids", seq_valids, 1);
        check("overrun temp", temp, 13'h0190);
        check("overrun sclk rises", n_rises - r0, FB);

        // Reset during SHIFT bit 7.
        sensor_q.delete(); sensor_q.push_back(16'hAAAA);
        r0 = n_rises;
        @(negedge clk);
        trig = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            trig = 1'b0;
        end
        check("abort rises before reset", n_rises - r0, 7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort state {cs_n,sclk,busy,valid,temp}",
              {bus.spi_cs_n_out, bus.spi_sclk_out, busy, valid, temp},
              {1'b1, 1'b0, 1'b0, 1'b0, 13'h0});
        cur_temp = '0;
        seq_valids = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (valid === 1'b1 || bus.spi_cs_n_out !== 1'b1) seq_valids++;
        end
        check("abort no activity after reset", seq_valids, 0);
        vq.delete(); vq.push_back(1'b1);
        fq.delete(); fq.push_back(16'h0C80);
        run_seq("after_abort");
        check("after abort temp", temp, 13'h0190);

        // Level held high for 500 cycles: one frame only.
        vq.delete();
        for (int i = 0; i < 500; i++) vq.push_back(1'b1);
        fq.delete(); fq.push_back(16'hE700); fq.push_back(16'h0C80);
        run_seq("held_high");
        check("held high valids", seq_valids, 1);
        check("held high temp", temp, 13'h1CE0);

        // Rises every 100 cycles, five times.
        vq.delete();
        for (int i = 0; i < 500; i++) vq.push_back((i % 100) < 10);
        fq.delete();
        for (int k = 0; k < 5; k++) fq.push_back(16'(k * 16'h0123 + 16'h0C80));
        run_seq("periodic");
        check("periodic valids", seq_valids, 5);
        check("periodic overruns", seq_ovr, 0);

        // Random trigger waveforms and random sensor frames.
        for (int r = 0; r < 3; r++) begin
            vq.delete();
            fq.delete();
            lvl = 0;
            while (vq.size() < 600) begin
                len = $urandom_range(1, 90);
                for (int k = 0; k < len && vq.size() < 600; k++) vq.push_back(lvl[0]);
                lvl = 1 - lvl;
            end
            for (int k = 0; k < 12; k++) fq.push_back(16'($urandom));
            run_seq($sformatf("rand%0d", r));
            check($sformatf("rand%0d valid count", r), seq_valids, model_valids);
        end

        check("sclk never high with cs_n high", n_sclk_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
